// File: rtl/vga_scanout_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_scanout_pkg
// Purpose  : Default 640x480@60 raster timing, total derivation and scanout
//            FSM state encoding shared by the VGA scanout block.
// Revision : 1.0 - initial release
// ============================================================================
package vga_scanout_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  // Stream-to-raster alignment state.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } scan_state_e;

  // Total clocks per line (or lines per frame) from the four timing segments.
  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_scanout_timing
// Purpose  : Horizontal/vertical raster counters with combinational decode of
//            the active region, sync windows, frame origin and last pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout_timing
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset_n,
  output logic active_o,
  output logic hs_act_o,
  output logic vs_act_o,
  output logic frame_start_o,
  output logic last_pix_o
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  int            w_h;
  int            w_v;

  assign w_h = int'(h_cnt_q);
  assign w_v = int'(v_cnt_q);

  // Next raster position: h wraps each line and carries into v.
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (w_h == H_TOTAL - 1) begin
      h_cnt_d = '0;
      if (w_v == V_TOTAL - 1) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end
  end

  // Raster position registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o      = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign hs_act_o      = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
  assign vs_act_o      = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
  assign frame_start_o = (w_h == 0) && (w_v == 0);
  assign last_pix_o    = (w_h == H_ACTIVE - 1) && (w_v == V_ACTIVE - 1);

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Purpose  : Locks a 24-bit pixel stream to the VGA raster and drives the DAC
//            pins through a single output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        locked,
  output logic        underflow,
  output logic        frame_start
);

  logic w_active;
  logic w_hs_act;
  logic w_vs_act;
  logic w_origin;
  logic w_last;
  logic w_misframe;

  scan_state_e state_q, state_d;
  logic        ready_d;
  logic        show_d;
  logic        underflow_d;

  logic [23:0] pix_q;
  logic        blank_n_q;
  logic        hs_q;
  logic        vs_q;
  logic        underflow_q;
  logic        frame_start_q;

  vga_scanout_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .reset_n       (reset_n),
    .active_o      (w_active),
    .hs_act_o      (w_hs_act),
    .vs_act_o      (w_vs_act),
    .frame_start_o (w_origin),
    .last_pix_o    (w_last)
  );

  // A beat is misframed when its sop/eop flags disagree with the raster slot.
  assign w_misframe = (in_sop != w_origin) || (in_eop != w_last);

  // Alignment decisions for the current slot: ready, display and state change.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    show_d      = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // Drain stale beats; hold a sop beat for the next frame origin.
        ready_d = in_valid && !in_sop;
        if (in_valid && in_sop) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_origin) begin
          ready_d = 1'b1;
          if (in_valid && !w_misframe) begin
            state_d = ST_LOCKED;
            show_d  = 1'b1;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      end
      ST_LOCKED: begin
        ready_d = w_active;
        if (w_active) begin
          if (!in_valid) begin
            underflow_d = 1'b1;
            state_d     = ST_SEARCH;
          end else if (w_misframe) begin
            state_d = ST_SEARCH;
          end else begin
            show_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // FSM state plus the output register stage shared by colour and sync pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_SEARCH;
      pix_q         <= '0;
      blank_n_q     <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= show_d ? in_data : 24'd0;
      blank_n_q     <= show_d;
      hs_q          <= w_hs_act ? HS_POL : ~HS_POL;
      vs_q          <= w_vs_act ? VS_POL : ~VS_POL;
      underflow_q   <= underflow_d;
      frame_start_q <= w_origin;
    end
  end

  // Ready is held low while reset is applied so no beat is consumed.
  assign in_ready    = reset_n && ready_d;
  assign vga_r       = pix_q[23:16];
  assign vga_g       = pix_q[15:8];
  assign vga_b       = pix_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign locked      = (state_q == ST_LOCKED);
  assign underflow   = underflow_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Purpose  : Directed, self-checking bench for vga_scanout on a 14x7 raster
//            (8x4 visible).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  localparam int NPIX = 32;   // 8 x 4 visible pixels per frame

  logic        clk;
  logic        reset_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic        locked;
  logic        underflow;
  logic        frame_start;

  vga_scanout #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .locked      (locked),
    .underflow   (underflow),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int          total = 0;
  int          bad   = 0;
  int          p     = 0;     // raster index (h + 14*v) of the counters this cycle
  int          last_p = -1;   // raster index the pins currently reflect
  int          k     = 0;     // source pixel index
  int          drop_p = -1;
  int          sop_p  = -1;
  logic        last_ready;
  logic        last_acc;
  logic [23:0] last_data;
  int          w_blank, w_uf, w_hs, w_vs, w_fs;

  typedef struct {
    int p;
    bit valid;
    bit sop;
    bit rdy;
    bit hs;
    bit vs;
    bit fs;
  } vec_t;

  vec_t tv[12];

  function automatic logic [23:0] pix(input int idx);
    return {8'(idx), 8'(idx + 64), 8'(idx ^ 170)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: sample handshake, take the edge, then check the shown pixel.
  task automatic cycle();
    #1;
    last_ready = in_ready;
    last_acc   = in_valid && in_ready;
    last_data  = in_data;
    @(posedge clk);
    #1;
    last_p = p;
    p++;
    if (vga_blank_n) begin
      chk($sformatf("p%0d shown_without_accept", last_p), last_acc, 1);
      chk($sformatf("p%0d pixel", last_p), {vga_r, vga_g, vga_b}, last_data);
    end
    w_blank += int'(vga_blank_n);
    w_uf    += int'(underflow);
    w_hs    += int'(!vga_hs);
    w_vs    += int'(!vga_vs);
    w_fs    += int'(frame_start);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    cycle();
  endtask

  // Frame source: presents pixel k, with optional dropped valid or stray sop.
  task automatic feed_cycle();
    in_valid = (p != drop_p);
    in_data  = pix(k);
    in_sop   = (k == 0) || (p == sop_p);
    in_eop   = (k == NPIX - 1);
    cycle();
    if (last_acc) k = (k + 1) % NPIX;
  endtask

  task automatic clear_win();
    w_blank = 0; w_uf = 0; w_hs = 0; w_vs = 0; w_fs = 0;
  endtask

  task automatic check_win(input string tag, input int blank, input int uf);
    chk({tag, " blank_n_count"}, w_blank, blank);
    chk({tag, " underflow_count"}, w_uf, uf);
    chk({tag, " hs_low_count"}, w_hs, 14);
    chk({tag, " vs_low_count"}, w_vs, 14);
    chk({tag, " frame_start_count"}, w_fs, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " hs"}, vga_hs, 1);
    chk({tag, " vs"}, vga_vs, 1);
    chk({tag, " blank_n"}, vga_blank_n, 0);
    chk({tag, " rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, " sync_n"}, vga_sync_n, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " underflow"}, underflow, 0);
    chk({tag, " frame_start"}, frame_start, 0);
    chk({tag, " in_ready"}, in_ready, 0);
  endtask

  initial begin
    //        p   vld sop rdy hs vs fs
    tv[0]  = '{0,  0,  0,  0,  1, 1, 1};
    tv[1]  = '{9,  1,  0,  1,  1, 1, 0};
    tv[2]  = '{10, 0,  0,  0,  0, 1, 0};
    tv[3]  = '{11, 1,  0,  1,  0, 1, 0};
    tv[4]  = '{12, 0,  0,  0,  1, 1, 0};
    tv[5]  = '{13, 0,  0,  0,  1, 1, 0};
    tv[6]  = '{70, 1,  0,  1,  1, 0, 0};
    tv[7]  = '{80, 0,  0,  0,  0, 0, 0};
    tv[8]  = '{83, 0,  0,  0,  1, 0, 0};
    tv[9]  = '{84, 0,  0,  0,  1, 1, 0};
    tv[10] = '{97, 0,  0,  0,  1, 1, 0};
    tv[11] = '{98, 0,  0,  0,  1, 1, 1};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    clear_win();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("por");
    reset_n = 1'b1;
    p = 0;

    // Free-running raster with no stream, occasional non-sop beats drained.
    for (int i = 0; i < 12; i++) begin
      while (p < tv[i].p) idle_cycle();
      in_valid = tv[i].valid;
      in_sop   = tv[i].sop;
      in_eop   = 1'b0;
      in_data  = 24'h123456;
      cycle();
      chk($sformatf("A p%0d in_ready", tv[i].p), last_ready, tv[i].rdy);
      chk($sformatf("A p%0d hs", tv[i].p), vga_hs, tv[i].hs);
      chk($sformatf("A p%0d vs", tv[i].p), vga_vs, tv[i].vs);
      chk($sformatf("A p%0d frame_start", tv[i].p), frame_start, tv[i].fs);
      chk($sformatf("A p%0d blank_n", tv[i].p), vga_blank_n, 0);
      chk($sformatf("A p%0d locked", tv[i].p), locked, 0);
      in_valid = 1'b0;
    end

    // Stream from sop mid-frame: armed until origin, then a full clean frame.
    k = 0;
    while (p < 150) feed_cycle();
    chk("B armed in_ready", last_ready, 0);
    chk("B armed locked", locked, 0);
    while (p < 196) feed_cycle();
    clear_win();
    feed_cycle();
    chk("B origin in_ready", last_ready, 1);
    chk("B origin locked", locked, 1);
    chk("B origin blank_n", vga_blank_n, 1);
    chk("B origin rgb", {vga_r, vga_g, vga_b}, pix(0));
    while (p < 294) feed_cycle();
    check_win("B frame", 32, 0);

    // Valid dropped at (3,2): underflow, drain of the rest, relock.
    drop_p = 294 + 2 * 14 + 3;
    clear_win();
    while (p <= drop_p) feed_cycle();
    chk("C underflow", underflow, 1);
    chk("C blank_n", vga_blank_n, 0);
    chk("C rgb", {vga_r, vga_g, vga_b}, 0);
    chk("C locked", locked, 0);
    while (p <= 330) feed_cycle();
    chk("C drain in_ready", last_ready, 1);
    while (p <= 360) feed_cycle();
    chk("C armed in_ready", last_ready, 0);
    chk("C armed locked", locked, 0);
    while (p < 392) feed_cycle();
    check_win("C frame", 19, 1);
    drop_p = -1;
    clear_win();
    feed_cycle();
    chk("C relock locked", locked, 1);
    chk("C relock blank_n", vga_blank_n, 1);
    while (p < 490) feed_cycle();
    check_win("C2 frame", 32, 0);

    // Stray sop at (5,1): lock dropped, rest of frame blank, sync unaffected.
    sop_p = 490 + 14 + 5;
    clear_win();
    while (p <= sop_p) feed_cycle();
    chk("D stray sop locked", locked, 0);
    chk("D stray sop blank_n", vga_blank_n, 0);
    chk("D stray sop underflow", underflow, 0);
    while (p <= 520) feed_cycle();
    chk("D drain in_ready", last_ready, 1);
    while (p <= 560) feed_cycle();
    chk("D armed in_ready", last_ready, 0);
    while (p < 588) feed_cycle();
    check_win("D frame", 13, 0);
    sop_p = -1;

    // Reset pulse at (4,2) while locked.
    while (p < 588 + 2 * 14 + 4) feed_cycle();
    chk("E pre-reset locked", locked, 1);
    reset_n = 1'b0;
    feed_cycle();
    check_reset("E reset");
    reset_n = 1'b1;
    p = 0;
    k = 0;
    feed_cycle();
    chk("E counters at origin", frame_start, 1);
    chk("E after reset locked", locked, 0);
    while (p < 98) feed_cycle();
    feed_cycle();
    chk("E relock locked", locked, 1);
    chk("E relock blank_n", vga_blank_n, 1);
    chk("E relock rgb", {vga_r, vga_g, vga_b}, pix(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
